preg_free_list: RTL and testbench



---
 rtl/preg_free_list_if.sv | 26 ++
 rtl/preg_free_list.sv | 83 ++++++++
 tb/tb_preg_free_list.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/preg_free_list_if.sv
// Rename/retire-side handshake bundle for the physical register free list.
// The master is the rename/retire pipeline; the slave is the free list itself.
interface preg_free_list_if #(
  parameter int PREG_WIDTH = 6
);
  logic                  alloc_req;
  logic                  alloc_valid;
  logic [PREG_WIDTH-1:0] alloc_tag;
  logic                  commit_valid;
  logic                  free_valid;
  logic [PREG_WIDTH-1:0] free_tag;
  logic                  flush;
  logic [PREG_WIDTH:0]   free_count;
  logic                  full;
  logic                  err;

  modport master (
    output alloc_req, commit_valid, free_valid, free_tag, flush,
    input  alloc_valid, alloc_tag, free_count, full, err
  );

  modport slave (
    input  alloc_req, commit_valid, free_valid, free_tag, flush,
    output alloc_valid, alloc_tag, free_count, full, err
  );
endinterface

// File: rtl/preg_free_list.sv
// Circular FIFO of free physical register tags. Rename pops from the
// speculative head, retire pushes old tags at the tail, and a committed head
// lets a flush hand every speculatively allocated tag back in one cycle.
// NUM_PREG must equal 2**PREG_WIDTH so pointer wrap is a plain overflow of
// the low PREG_WIDTH bits; the extra MSB distinguishes full from empty.
module preg_free_list #(
  parameter int PREG_WIDTH = 6,
  parameter int NUM_AREG   = 32,
  parameter int NUM_PREG   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  preg_free_list_if.slave       bus
);
  localparam int PTR_W = PREG_WIDTH + 1;

  logic [PREG_WIDTH-1:0] mem_q [NUM_PREG];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      commit_head_q, commit_head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic                  err_q, err_d;

  logic alloc_fire;
  logic commit_fire;
  logic free_fire;
  logic full;

  // Outputs are decoded straight from registered state; no free->alloc bypass.
  assign full             = (tail_q - commit_head_q) == PTR_W'(NUM_PREG);
  assign bus.alloc_valid  = (head_q != tail_q);
  assign bus.alloc_tag    = mem_q[head_q[PREG_WIDTH-1:0]];
  assign bus.free_count   = tail_q - head_q;
  assign bus.full         = full;
  assign bus.err          = err_q;

  // Qualify each request; tag 0 is the hardwired x0 mapping and never recycled.
  assign alloc_fire  = bus.alloc_req && bus.alloc_valid && !bus.flush;
  assign commit_fire = bus.commit_valid && (commit_head_q != head_q);
  assign free_fire   = bus.free_valid && (bus.free_tag != '0) && !full;

  // Next-state for the three pointers and the sticky error flag.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    head_d        = head_q;
    commit_head_d = commit_head_q;
    tail_d        = tail_q;
    err_d         = err_q;

    if (commit_fire) commit_head_d = commit_head_q + PTR_W'(1);

    // Flush rewinds to the committed head, including a commit landing this cycle.
    if (bus.flush)       head_d = commit_head_d;
    else if (alloc_fire) head_d = head_q + PTR_W'(1);

    if (free_fire) tail_d = tail_q + PTR_W'(1);

    if (bus.free_valid && (bus.free_tag != '0) && full) err_d = 1'b1;
    if (bus.commit_valid && (commit_head_q == head_q))  err_d = 1'b1;
  end

  // Pointer, error and storage registers with a synchronous reset image.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q        <= '0;
      commit_head_q <= '0;
      tail_q        <= PTR_W'(NUM_PREG - NUM_AREG);
      err_q         <= 1'b0;
      // NOTE: the storage is reset on purpose -- the initial free tags live in
      // the array itself, so a reset must rebuild that image, not just the pointers.
      for (int i = 0; i < NUM_PREG - NUM_AREG; i++) begin
        mem_q[i] <= PREG_WIDTH'(NUM_AREG + i);
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers
      // sample the same pre-edge values regardless of statement order.
      head_q        <= head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
      err_q         <= err_d;
      if (free_fire) mem_q[tail_q[PREG_WIDTH-1:0]] <= bus.free_tag;
    end
  end
endmodule

// File: tb/tb_preg_free_list.sv
// Directed self-checking bench for preg_free_list with hand-computed expectations.
module tb_preg_free_list;
  localparam int PREG_WIDTH = 6;
  localparam int NUM_AREG   = 32;
  localparam int NUM_PREG   = 64;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  preg_free_list_if #(.PREG_WIDTH(PREG_WIDTH)) bus ();

  preg_free_list #(
    .PREG_WIDTH (PREG_WIDTH),
    .NUM_AREG   (NUM_AREG),
    .NUM_PREG   (NUM_PREG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle, so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alloc_req    = 1'b0;
    bus.commit_valid = 1'b0;
    bus.free_valid   = 1'b0;
    bus.free_tag     = '0;
    bus.flush        = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.alloc_req = 1'b1;
      tick();
    end
    bus.alloc_req = 1'b0;
  endtask

  task automatic commit_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.commit_valid = 1'b1;
      tick();
    end
    bus.commit_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;

    // Reset image after one idle cycle.
    tick();
    check("rst_free_count", int'(bus.free_count), 32);
    check("rst_alloc_tag", int'(bus.alloc_tag), 32);
    check("rst_alloc_valid", int'(bus.alloc_valid), 1);
    check("rst_full", int'(bus.full), 0);
    check("rst_err", int'(bus.err), 0);

    // Drain all 32 free tags in order, then try once more while empty.
    for (int i = 0; i < 32; i++) begin
      check($sformatf("drain_tag%0d", i), int'(bus.alloc_tag), 32 + i);
      bus.alloc_req = 1'b1;
      tick();
    end
    bus.alloc_req = 1'b0;
    check("empty_valid", int'(bus.alloc_valid), 0);
    check("empty_count", int'(bus.free_count), 0);
    bus.alloc_req = 1'b1;
    tick();
    bus.alloc_req = 1'b0;
    check("empty_alloc_count", int'(bus.free_count), 0);
    check("empty_alloc_valid", int'(bus.alloc_valid), 0);
    check("empty_alloc_err", int'(bus.err), 0);

    // From empty: free tag 5 with alloc_req in the same cycle, no bypass.
    bus.free_valid = 1'b1;
    bus.free_tag   = 6'd5;
    bus.alloc_req  = 1'b1;
    tick();
    idle_inputs();
    check("refill_valid", int'(bus.alloc_valid), 1);
    check("refill_tag", int'(bus.alloc_tag), 5);
    check("refill_count", int'(bus.free_count), 1);

    // Allocate 3, commit 1, flush: head returns to 1.
    do_reset();
    alloc_n(3);
    check("alloc3_tag", int'(bus.alloc_tag), 35);
    commit_n(1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_tag", int'(bus.alloc_tag), 33);
    check("flush_count", int'(bus.free_count), 31);
    check("flush_err", int'(bus.err), 0);

    // Commit and flush together: head lands on commit_head+1.
    alloc_n(2);
    bus.commit_valid = 1'b1;
    bus.flush        = 1'b1;
    bus.alloc_req    = 1'b1;
    tick();
    idle_inputs();
    check("cflush_tag", int'(bus.alloc_tag), 34);
    check("cflush_count", int'(bus.free_count), 30);

    // Alloc, commit and free all in one cycle.
    do_reset();
    alloc_n(2);
    bus.alloc_req    = 1'b1;
    bus.commit_valid = 1'b1;
    bus.free_valid   = 1'b1;
    bus.free_tag     = 6'd7;
    tick();
    idle_inputs();
    check("triple_tag", int'(bus.alloc_tag), 35);
    check("triple_count", int'(bus.free_count), 30);
    check("triple_err", int'(bus.err), 0);

    // Tag 0 is never returned; commit with nothing allocated flags err.
    do_reset();
    bus.free_valid = 1'b1;
    bus.free_tag   = 6'd0;
    tick();
    idle_inputs();
    check("free0_count", int'(bus.free_count), 32);
    check("free0_err", int'(bus.err), 0);
    commit_n(1);
    check("bad_commit_err", int'(bus.err), 1);
    check("bad_commit_count", int'(bus.free_count), 32);

    // Alloc 4 / commit 4 leaves 28 occupied; 36 frees reach full.
    do_reset();
    alloc_n(4);
    commit_n(4);
    for (int i = 0; i < 36; i++) begin
      bus.free_valid = 1'b1;
      bus.free_tag   = 6'(i + 1);
      tick();
      if (i == 34) check("almost_full", int'(bus.full), 0);
    end
    idle_inputs();
    check("full_flag", int'(bus.full), 1);
    check("full_count", int'(bus.free_count), 64);
    check("full_tag", int'(bus.alloc_tag), 36);
    check("full_err_before", int'(bus.err), 0);
    bus.free_valid = 1'b1;
    bus.free_tag   = 6'd40;
    tick();
    idle_inputs();
    check("overflow_err", int'(bus.err), 1);
    check("overflow_count", int'(bus.free_count), 64);

    // Reset asserted with requests pending: reset wins.
    bus.alloc_req    = 1'b1;
    bus.free_valid   = 1'b1;
    bus.free_tag     = 6'd9;
    bus.commit_valid = 1'b1;
    rst              = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    tick();
    check("rerst_count", int'(bus.free_count), 32);
    check("rerst_tag", int'(bus.alloc_tag), 32);
    check("rerst_full", int'(bus.full), 0);
    check("rerst_err", int'(bus.err), 0);
    check("rerst_valid", int'(bus.alloc_valid), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
